// File: rtl/wb_seq_pkg.sv
// Shared types and helpers for the write-back tile sequencer.
// Contents:
//   wb_seq_state_t  sequencer state encoding (ST_ERR is reachable only when
//                   WB_SEQ_WDOG_EN is defined)
//   BPW             bytes per memory word for the default 64-bit memory
//   beats_for()     memory write beats needed for a tile with n active FIFOs
package wb_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TILE = 3'd1,
    ST_START     = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_ERR       = 3'd5
  } wb_seq_state_t;

  localparam int unsigned MEM_DATA_WIDTH_DEF = 64;
  localparam int unsigned BPW                = MEM_DATA_WIDTH_DEF / 8;

  // Each of the n FIFOs writes ceil(n/bpw) words, so the total is n*ceil(n/bpw).
  function automatic logic [5:0] beats_for(input logic [4:0] n, input int unsigned bpw = BPW);
    int unsigned nn;
    int unsigned words;
    nn    = 32'(n);
    words = (nn + bpw - 1) / bpw;
    return 6'(nn * words);
  endfunction

endpackage

// File: rtl/wb_seq_watchdog.sv
// Write-progress watchdog for the write-back tile sequencer.
// Built only when WB_SEQ_WDOG_EN is defined.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      restart the count (tile start, accepted write beat, abort)
//   count_en   count while the sequencer is waiting on write beats
//   expired    count_en is high and WDOG_CYCLES cycles have passed with no clear
module wb_seq_watchdog #(
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = count_en && (cnt_q == CW'(WDOG_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_tile_sequencer.sv
// Multi-tile output write-back sequencer.
// For each systolic-array result tile it drives base address and active FIFO
// count into the write_back engine, pulses wb_start, forwards memory write acks
// as wb_data_written, counts beats to find the end of the tile, then releases
// the array buffer (tile_ack) and moves to the next tile.
// Optional feature macro: WB_SEQ_WDOG_EN adds a write watchdog, an ERR state,
// the WDOG_CYCLES parameter and the err_flag output.
// Ports:
//   clk, rst, clr                    clock, sync reset, sync abort
//   cfg_*  / cfg_ready               layer configuration handshake (IDLE only)
//   tile_valid / tile_ack            systolic array result buffer handshake
//   mem_wr_ack                       memory accepted a write word
//   wb_clr, wb_start, wb_base_addr,
//   wb_stride_chan, wb_fifo_num,
//   wb_data_written                  write_back engine control
//   busy, all_done, tile_idx         status
//   err_flag                         sticky watchdog error (WB_SEQ_WDOG_EN only)
//
// state        | meaning
// IDLE         | waiting for a layer configuration
// WAIT_TILE    | waiting for the array to hold a finished tile
// START        | one-cycle start pulse into write_back
// WRITE        | counting memory write beats for the current tile
// RELEASE      | release array buffer, advance address / tile index
// ERR          | watchdog expired, abort write_back (WB_SEQ_WDOG_EN only)
module wb_tile_sequencer
  import wb_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned ARRAY_SIZE     = 16,
  parameter int unsigned TILE_W         = 8
`ifdef WB_SEQ_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES    = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TILE_W-1:0]     cfg_num_tiles,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_tile_step,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_chan,
  input  logic [4:0]            cfg_last_fifo_num,
  input  logic                  tile_valid,
  output logic                  tile_ack,
  input  logic                  mem_wr_ack,
  output logic                  wb_clr,
  output logic                  wb_start,
  output logic [ADDR_WIDTH-1:0] wb_base_addr,
  output logic [ADDR_WIDTH-1:0] wb_stride_chan,
  output logic [4:0]            wb_fifo_num,
  output logic                  wb_data_written,
  output logic                  busy,
  output logic                  all_done,
  output logic [TILE_W-1:0]     tile_idx
`ifdef WB_SEQ_WDOG_EN
  ,
  output logic                  err_flag
`endif
);

  localparam int unsigned BPW_L = MEM_DATA_WIDTH / 8;

  wb_seq_state_t         state_q, state_d;
  logic [TILE_W-1:0]     num_tiles_q, num_tiles_d;
  logic [ADDR_WIDTH-1:0] step_q, step_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [4:0]            last_fifo_q, last_fifo_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [TILE_W-1:0]     tile_idx_q, tile_idx_d;
  logic [4:0]            fifo_num_q, fifo_num_d;
  logic [5:0]            beats_exp_q, beats_exp_d;
  logic [5:0]            beat_cnt_q, beat_cnt_d;
  logic                  all_done_q, all_done_d;
  logic                  wb_clr_q, wb_clr_d;

  logic                  last_tile;
  logic [4:0]            fifo_sel;
  logic                  wdog_expired;

  assign last_tile = (tile_idx_q == num_tiles_q - TILE_W'(1));

  // Only the last tile may be partial; 0 or out-of-range means a full tile.
  assign fifo_sel = (!last_tile || last_fifo_q == 5'd0 || last_fifo_q > 5'(ARRAY_SIZE))
                    ? 5'(ARRAY_SIZE) : last_fifo_q;

`ifdef WB_SEQ_WDOG_EN
  logic err_flag_q, err_flag_d;

  wb_seq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr || state_q == ST_START || (state_q == ST_WRITE && mem_wr_ack)),
    .count_en (state_q == ST_WRITE),
    .expired  (wdog_expired)
  );

  assign err_flag = err_flag_q;
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    num_tiles_d = num_tiles_q;
    step_d      = step_q;
    stride_d    = stride_q;
    last_fifo_d = last_fifo_q;
    cur_addr_d  = cur_addr_q;
    tile_idx_d  = tile_idx_q;
    fifo_num_d  = fifo_num_q;
    beats_exp_d = beats_exp_q;
    beat_cnt_d  = beat_cnt_q;
    all_done_d  = 1'b0;
    wb_clr_d    = 1'b0;
`ifdef WB_SEQ_WDOG_EN
    err_flag_d  = err_flag_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          num_tiles_d = cfg_num_tiles;
          step_d      = cfg_tile_step;
          stride_d    = cfg_stride_chan;
          last_fifo_d = cfg_last_fifo_num;
          cur_addr_d  = cfg_base_addr;
          tile_idx_d  = '0;
          beat_cnt_d  = '0;
`ifdef WB_SEQ_WDOG_EN
          err_flag_d  = 1'b0;
`endif
          if (cfg_num_tiles == '0) begin
            all_done_d = 1'b1;
          end else begin
            state_d = ST_WAIT_TILE;
          end
        end
      end
      ST_WAIT_TILE: begin
        if (tile_valid) begin
          fifo_num_d  = fifo_sel;
          beats_exp_d = beats_for(fifo_sel, BPW_L);
          state_d     = ST_START;
        end
      end
      ST_START: begin
        beat_cnt_d = '0;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        // A beat in the same cycle as expiry counts as progress.
        if (mem_wr_ack) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
          if (beat_cnt_q == beats_exp_q - 6'd1) begin
            state_d = ST_RELEASE;
          end
        end else if (wdog_expired) begin
`ifdef WB_SEQ_WDOG_EN
          err_flag_d = 1'b1;
`endif
          state_d = ST_ERR;
        end
      end
      ST_RELEASE: begin
        cur_addr_d = cur_addr_q + step_q;
        if (last_tile) begin
          state_d = ST_IDLE;
        end else begin
          tile_idx_d = tile_idx_q + TILE_W'(1);
          state_d    = ST_WAIT_TILE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clr) begin
      state_d    = ST_IDLE;
      cur_addr_d = '0;
      tile_idx_d = '0;
      beat_cnt_d = '0;
      all_done_d = 1'b0;
      wb_clr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_tiles_q <= '0;
      step_q      <= '0;
      stride_q    <= '0;
      last_fifo_q <= '0;
      cur_addr_q  <= '0;
      tile_idx_q  <= '0;
      fifo_num_q  <= '0;
      beats_exp_q <= '0;
      beat_cnt_q  <= '0;
      all_done_q  <= 1'b0;
      wb_clr_q    <= 1'b0;
`ifdef WB_SEQ_WDOG_EN
      err_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      num_tiles_q <= num_tiles_d;
      step_q      <= step_d;
      stride_q    <= stride_d;
      last_fifo_q <= last_fifo_d;
      cur_addr_q  <= cur_addr_d;
      tile_idx_q  <= tile_idx_d;
      fifo_num_q  <= fifo_num_d;
      beats_exp_q <= beats_exp_d;
      beat_cnt_q  <= beat_cnt_d;
      all_done_q  <= all_done_d;
      wb_clr_q    <= wb_clr_d;
`ifdef WB_SEQ_WDOG_EN
      err_flag_q  <= err_flag_d;
`endif
    end
  end

  assign cfg_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign wb_start        = (state_q == ST_START);
  assign tile_ack        = (state_q == ST_RELEASE);
  assign wb_data_written = (state_q == ST_WRITE) && mem_wr_ack;
  // Zero-tile layers finish from a register; normal layers finish with the last release.
  assign all_done        = all_done_q || (state_q == ST_RELEASE && last_tile);
  assign wb_clr          = wb_clr_q || (state_q == ST_ERR);
  assign wb_base_addr    = cur_addr_q;
  assign wb_stride_chan  = stride_q;
  assign wb_fifo_num     = fifo_num_q;
  assign tile_idx        = tile_idx_q;

endmodule

// File: tb/tb_wb_tile_sequencer.sv
module tb_wb_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst, clr, cfg_valid, cfg_ready;
  logic [7:0] cfg_num_tiles, cfg_base_addr, cfg_tile_step, cfg_stride_chan;
  logic [4:0] cfg_last_fifo_num;
  logic       tile_valid, tile_ack, mem_wr_ack, wb_clr, wb_start;
  logic [7:0] wb_base_addr, wb_stride_chan;
  logic [4:0] wb_fifo_num;
  logic       wb_data_written, busy, all_done;
  logic [7:0] tile_idx;
`ifdef WB_SEQ_WDOG_EN
  logic       err_flag;
`endif

  always #5 clk = ~clk;

  wb_tile_sequencer #(
    .ADDR_WIDTH     (8),
    .MEM_DATA_WIDTH (64),
    .ARRAY_SIZE     (16),
    .TILE_W         (8)
`ifdef WB_SEQ_WDOG_EN
    ,
    .WDOG_CYCLES    (16)
`endif
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .clr               (clr),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_num_tiles     (cfg_num_tiles),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_tile_step     (cfg_tile_step),
    .cfg_stride_chan   (cfg_stride_chan),
    .cfg_last_fifo_num (cfg_last_fifo_num),
    .tile_valid        (tile_valid),
    .tile_ack          (tile_ack),
    .mem_wr_ack        (mem_wr_ack),
    .wb_clr            (wb_clr),
    .wb_start          (wb_start),
    .wb_base_addr      (wb_base_addr),
    .wb_stride_chan    (wb_stride_chan),
    .wb_fifo_num       (wb_fifo_num),
    .wb_data_written   (wb_data_written),
    .busy              (busy),
    .all_done          (all_done),
    .tile_idx          (tile_idx)
`ifdef WB_SEQ_WDOG_EN
    ,
    .err_flag          (err_flag)
`endif
  );

  typedef struct {
    logic [7:0] addr;
    logic [4:0] fifo;
  } start_exp_t;

  typedef struct {
    int   beats;
    logic last;
  } tile_exp_t;

  start_exp_t start_q[$];
  tile_exp_t  tile_q[$];
  int total = 0;
  int bad   = 0;
  int beat_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_tile(input logic [7:0] addr, input logic [4:0] fifo, input int beats,
                             input logic last);
    start_exp_t s;
    tile_exp_t  t;
    s.addr = addr; s.fifo = fifo;
    t.beats = beats; t.last = last;
    start_q.push_back(s);
    tile_q.push_back(t);
  endtask

  // Monitor / scoreboard: compares every start and every tile release against the queues.
  always @(negedge clk) begin
    start_exp_t s;
    tile_exp_t  t;
    if (!rst) begin
      if (wb_clr) begin
        start_q.delete();
        tile_q.delete();
        beat_seen = 0;
      end else begin
        if (wb_data_written) beat_seen++;
        if (wb_start) begin
          if (start_q.size() == 0) begin
            check("unexpected_wb_start", 32'd1, 32'd0);
          end else begin
            s = start_q.pop_front();
            check("start_base_addr", 32'(wb_base_addr), 32'(s.addr));
            check("start_fifo_num", 32'(wb_fifo_num), 32'(s.fifo));
          end
        end
        if (tile_ack) begin
          if (tile_q.size() == 0) begin
            check("unexpected_tile_ack", 32'd1, 32'd0);
          end else begin
            t = tile_q.pop_front();
            check("tile_beats", 32'(beat_seen), 32'(t.beats));
            check("tile_all_done", 32'(all_done), 32'(t.last));
          end
          beat_seen = 0;
        end
      end
    end
  end

  task automatic do_cfg(input logic [7:0] n, input logic [7:0] base, input logic [7:0] step,
                        input logic [7:0] stride, input logic [4:0] last);
    @(negedge clk);
    check("cfg_ready_before_cfg", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_num_tiles = n; cfg_base_addr = base; cfg_tile_step = step;
    cfg_stride_chan = stride; cfg_last_fifo_num = last;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Present a tile, wait for its start, then deliver nacks write acks (with one gap).
  task automatic run_tile(input int nacks, input bit pre_ack, input bit wait_ack);
    int k;
    if (pre_ack) begin
      @(posedge clk); #1;
      mem_wr_ack = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("data_written_in_wait_tile", 32'(wb_data_written), 32'd0);
      end
    end
    @(posedge clk); #1;
    tile_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (wb_start) break;
      k++;
      if (k > 20) begin
        check("wb_start_timeout", 32'd1, 32'd0);
        tile_valid = 1'b0;
        mem_wr_ack = 1'b0;
        return;
      end
    end
    if (pre_ack) check("data_written_in_start", 32'(wb_data_written), 32'd0);
    for (int i = 0; i < nacks; i++) begin
      if (i == 3) begin
        @(posedge clk); #1;
        mem_wr_ack = 1'b0;
        tile_valid = 1'b0;
      end
      @(posedge clk); #1;
      mem_wr_ack = 1'b1;
      tile_valid = 1'b0;
    end
    @(posedge clk); #1;
    mem_wr_ack = 1'b0;
    if (wait_ack) begin
      k = 0;
      forever begin
        @(negedge clk);
        if (tile_ack) break;
        k++;
        if (k > 10) begin
          check("tile_ack_timeout", 32'd1, 32'd0);
          return;
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1; clr = 1'b0; cfg_valid = 1'b0; tile_valid = 1'b0; mem_wr_ack = 1'b0;
    cfg_num_tiles = '0; cfg_base_addr = '0; cfg_tile_step = '0;
    cfg_stride_chan = '0; cfg_last_fifo_num = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb_start", 32'(wb_start), 32'd0);
    check("rst_tile_ack", 32'(tile_ack), 32'd0);
    check("rst_all_done", 32'(all_done), 32'd0);
    check("rst_wb_clr", 32'(wb_clr), 32'd0);
    check("rst_wb_base_addr", 32'(wb_base_addr), 32'd0);
    check("rst_wb_fifo_num", 32'(wb_fifo_num), 32'd0);
    check("rst_tile_idx", 32'(tile_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // One full tile: 32 beats, tile_ack and all_done together, then idle.
    do_cfg(8'd1, 8'h00, 8'h10, 8'h07, 5'd16);
    expect_tile(8'h00, 5'd16, 32, 1'b1);
    @(negedge clk);
    check("stride_forwarded", 32'(wb_stride_chan), 32'h07);
    check("busy_after_cfg", 32'(busy), 32'd1);
    run_tile(32, 1'b0, 1'b1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("all_done_single_pulse", 32'(all_done), 32'd0);

    // Three tiles with a partial last tile; stray cfg and early acks are ignored.
    do_cfg(8'd3, 8'h10, 8'h40, 8'h02, 5'd5);
    expect_tile(8'h10, 5'd16, 32, 1'b0);
    expect_tile(8'h50, 5'd16, 32, 1'b0);
    expect_tile(8'h90, 5'd5, 5, 1'b1);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_num_tiles = 8'd0; cfg_base_addr = 8'hEE;
    @(negedge clk);
    check("cfg_ready_when_busy", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("tile_idx", 32'(tile_idx), 32'(t));
      run_tile((t == 2) ? 5 : 32, (t == 1), 1'b1);
    end
    @(negedge clk);
    check("busy_after_three", 32'(busy), 32'd0);

    // Address wrap and a 9-FIFO last tile (9*ceil(9/8) = 18 beats).
    do_cfg(8'd2, 8'hF0, 8'h20, 8'h01, 5'd9);
    expect_tile(8'hF0, 5'd16, 32, 1'b0);
    expect_tile(8'h10, 5'd9, 18, 1'b1);
    run_tile(32, 1'b0, 1'b1);
    run_tile(18, 1'b0, 1'b1);

    // Zero-tile layer: all_done next cycle, never a start.
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_num_tiles = 8'd0; cfg_base_addr = 8'h33;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("zero_tiles_all_done", 32'(all_done), 32'd1);
    check("zero_tiles_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("zero_tiles_all_done_pulse", 32'(all_done), 32'd0);

    // Abort after 10 acks of the first tile, then a fresh layer.
    do_cfg(8'd2, 8'h30, 8'h10, 8'h04, 5'd0);
    expect_tile(8'h30, 5'd16, 32, 1'b0);
    run_tile(10, 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_wb_clr", 32'(wb_clr), 32'd1);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_tile_ack", 32'(tile_ack), 32'd0);
    check("clr_all_done", 32'(all_done), 32'd0);
    check("clr_tile_idx", 32'(tile_idx), 32'd0);
    @(negedge clk);
    check("clr_wb_clr_pulse", 32'(wb_clr), 32'd0);
    do_cfg(8'd1, 8'h44, 8'h10, 8'h04, 5'd20);
    expect_tile(8'h44, 5'd16, 32, 1'b1);
    @(negedge clk);
    check("recfg_tile_idx", 32'(tile_idx), 32'd0);
    run_tile(32, 1'b0, 1'b1);

`ifdef WB_SEQ_WDOG_EN
    // No acks after start: watchdog aborts after 16 write cycles.
    do_cfg(8'd1, 8'h00, 8'h00, 8'h00, 5'd3);
    start_q.push_back('{addr: 8'h00, fifo: 5'd3});
    @(posedge clk); #1;
    tile_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (wb_start || k > 20) break;
      k++;
    end
    tile_valid = 1'b0;
    check("wdog_start_seen", 32'(wb_start), 32'd1);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (err_flag || k > 40) break;
    end
    check("wdog_cycles", 32'(k), 32'd17);
    check("wdog_err_flag", 32'(err_flag), 32'd1);
    check("wdog_wb_clr", 32'(wb_clr), 32'd1);
    @(negedge clk);
    check("wdog_idle", 32'(busy), 32'd0);
    check("wdog_err_sticky", 32'(err_flag), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_num_tiles = 8'd0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("wdog_err_cleared", 32'(err_flag), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("start_queue_drained", 32'(start_q.size()), 32'd0);
    check("tile_queue_drained", 32'(tile_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
